// File: rtl/ip_lcd_pkg.sv
// Panel timing constants and the colour-bar table shared by the LCD driver files.
package ip_lcd_pkg;

    localparam int unsigned CLK_DIV   = 3;

    localparam int unsigned H_ACTIVE  = 800;
    localparam int unsigned H_FP      = 40;
    localparam int unsigned H_SYNC    = 128;
    localparam int unsigned H_BP      = 88;
    localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned HS_START  = H_ACTIVE + H_FP;
    localparam int unsigned HS_END    = HS_START + H_SYNC;

    localparam int unsigned V_ACTIVE  = 480;
    localparam int unsigned V_FP      = 13;
    localparam int unsigned V_SYNC    = 3;
    localparam int unsigned V_BP      = 29;
    localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned VS_START  = V_ACTIVE + V_FP;
    localparam int unsigned VS_END    = VS_START + V_SYNC;

    localparam int unsigned HW        = 11;
    localparam int unsigned VW        = 10;
    localparam int unsigned BAR_WIDTH = 100;

    typedef struct packed {
        logic [4:0] r;
        logic [4:0] g;
        logic [4:0] b;
    } rgb_t;

    // white, yellow, cyan, green, magenta, red, blue, black
    localparam rgb_t COLOURS [8] = '{
        '{5'd31, 5'd31, 5'd31},
        '{5'd31, 5'd31, 5'd0 },
        '{5'd0,  5'd31, 5'd31},
        '{5'd0,  5'd31, 5'd0 },
        '{5'd31, 5'd0,  5'd31},
        '{5'd31, 5'd0,  5'd0 },
        '{5'd0,  5'd0,  5'd31},
        '{5'd0,  5'd0,  5'd0 }
    };

    // Compare chain instead of a divider; only meaningful for h < H_ACTIVE.
    function automatic logic [2:0] bar_of(input logic [HW-1:0] h);
        bar_of = '0;
        for (int unsigned i = 1; i < 8; i++) begin
            if (h >= HW'(i * BAR_WIDTH)) bar_of = 3'(i);
        end
    endfunction

endpackage

// File: rtl/ip_lcd_timing.sv
// Pixel-clock divider and horizontal/vertical position counters.
module ip_lcd_timing
    import ip_lcd_pkg::*;
#(
    parameter int unsigned H_TOTAL_PIX   = H_TOTAL,
    parameter int unsigned V_TOTAL_LINES = V_TOTAL
) (
    input  logic          clk,
    input  logic          n_reset,
    output logic          tick,
    output logic [HW-1:0] h,
    output logic [VW-1:0] v
);

    logic [$clog2(CLK_DIV)-1:0] div;

    assign tick = (div == ($clog2(CLK_DIV))'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            div <= '0;
            h   <= '0;
            v   <= '0;
        end else begin
            div <= tick ? '0 : div + ($clog2(CLK_DIV))'(1);
            if (tick) begin
                if (h == HW'(H_TOTAL_PIX - 1)) begin
                    h <= '0;
                    v <= (v == VW'(V_TOTAL_LINES - 1)) ? '0 : v + VW'(1);
                end else begin
                    h <= h + HW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/ip_lcd.sv
// 800x480 parallel-RGB LCD driver: sync/DE decode and an 8-bar test pattern,
// all outputs registered on the pixel tick.
module ip_lcd
    import ip_lcd_pkg::*;
#(
    parameter int unsigned V_ACT_LINES   = V_ACTIVE,
    parameter int unsigned VS_START_LINE = VS_START,
    parameter int unsigned VS_END_LINE   = VS_END,
    parameter int unsigned V_TOTAL_LINES = V_TOTAL
) (
    input  logic       clk,
    input  logic       n_reset,
    output logic       lcd_clk,
    output logic       lcd_de,
    output logic       lcd_hsync,
    output logic       lcd_vsync,
    output logic [4:0] lcd_red,
    output logic [4:0] lcd_green,
    output logic [4:0] lcd_blue
);

    logic          tick;
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          de_next;
    rgb_t          pix_next;

    ip_lcd_timing #(
        .H_TOTAL_PIX   (H_TOTAL),
        .V_TOTAL_LINES (V_TOTAL_LINES)
    ) u_timing (
        .clk     (clk),
        .n_reset (n_reset),
        .tick    (tick),
        .h       (h),
        .v       (v)
    );

    always_comb begin
        de_next  = (h < HW'(H_ACTIVE)) && (v < VW'(V_ACT_LINES));
        pix_next = de_next ? COLOURS[bar_of(h)] : '0;
    end

    // The divider returns to 0 exactly after a tick, so lcd_clk falls with the data update.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            lcd_clk   <= 1'b0;
            lcd_de    <= 1'b0;
            lcd_hsync <= 1'b1;
            lcd_vsync <= 1'b1;
            lcd_red   <= '0;
            lcd_green <= '0;
            lcd_blue  <= '0;
        end else begin
            lcd_clk <= !tick;
            if (tick) begin
                lcd_de    <= de_next;
                lcd_hsync <= !((h >= HW'(HS_START)) && (h < HW'(HS_END)));
                lcd_vsync <= !((v >= VW'(VS_START_LINE)) && (v < VW'(VS_END_LINE)));
                lcd_red   <= pix_next.r;
                lcd_green <= pix_next.g;
                lcd_blue  <= pix_next.b;
            end
        end
    end

endmodule

// File: tb/tb_ip_lcd.sv
// Directed bench for ip_lcd: full-width lines with a shortened vertical frame.
module tb_ip_lcd;

    localparam int unsigned TB_VA    = 4;
    localparam int unsigned TB_VS0   = 6;
    localparam int unsigned TB_VS1   = 9;
    localparam int unsigned TB_VT    = 11;
    localparam int RUN_CLKS = 3 * (17 * 1056 + 200);

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic       lcd_clk, lcd_de, lcd_hsync, lcd_vsync;
    logic [4:0] lcd_red, lcd_green, lcd_blue;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ip_lcd #(
        .V_ACT_LINES   (TB_VA),
        .VS_START_LINE (TB_VS0),
        .VS_END_LINE   (TB_VS1),
        .V_TOTAL_LINES (TB_VT)
    ) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .lcd_clk   (lcd_clk),
        .lcd_de    (lcd_de),
        .lcd_hsync (lcd_hsync),
        .lcd_vsync (lcd_vsync),
        .lcd_red   (lcd_red),
        .lcd_green (lcd_green),
        .lcd_blue  (lcd_blue)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic        prev_clk, prev_de, prev_hs, prev_vs;
    logic [17:0] prev_out, cur_out;
    logic [14:0] rgb, cap0, cap99, cap100, cap350, cap799;
    int last_rise, last_fall, first_fall_c, clk_rises, clk_bad, out_bad, x_bad, rgb_bad;
    int pix, lines, last_hs_fall, line_len, line_bad, hs_run, hs_low_len, hs_bad;
    int de_x, de_bad, de_runs_total, de_runs_frame, frame_de_lines;
    int last_vs_fall_line, frame_lines, vs_low_lines, vs_low_len, bp_lines;
    logic vs_rise_seen, bp_done, clk_fall;

    initial begin
        last_rise = -1; last_fall = -1; first_fall_c = -1;
        clk_rises = 0; clk_bad = 0; out_bad = 0; x_bad = 0; rgb_bad = 0;
        pix = 0; lines = 0; last_hs_fall = -1; line_len = 0; line_bad = 0;
        hs_run = 0; hs_low_len = 0; hs_bad = 0;
        de_x = 0; de_bad = 0; de_runs_total = 0; de_runs_frame = 0; frame_de_lines = 0;
        last_vs_fall_line = -1; frame_lines = 0; vs_low_lines = 0; vs_low_len = 0; bp_lines = 0;
        vs_rise_seen = 1'b0; bp_done = 1'b0;
        cap0 = 'x; cap99 = 'x; cap100 = 'x; cap350 = 'x; cap799 = 'x;

        // Reset held for two clocks
        repeat (2) @(negedge clk);
        chk("reset_clk", 32'(lcd_clk), 32'd0);
        chk("reset_de", 32'(lcd_de), 32'd0);
        chk("reset_syncs", 32'({lcd_hsync, lcd_vsync}), 32'b11);
        chk("reset_rgb", 32'({lcd_red, lcd_green, lcd_blue}), 32'd0);

        n_reset  = 1'b1;
        prev_clk = 1'b0;
        prev_out = {1'b0, 1'b1, 1'b1, 15'd0};

        for (int c = 0; c < RUN_CLKS; c++) begin
            @(negedge clk);
            rgb     = {lcd_red, lcd_green, lcd_blue};
            cur_out = {lcd_de, lcd_hsync, lcd_vsync, rgb};
            prev_de = prev_out[17];
            prev_hs = prev_out[16];
            prev_vs = prev_out[15];
            if ($isunknown({lcd_clk, cur_out})) x_bad++;
            clk_fall = prev_clk && !lcd_clk;
            if (!prev_clk && lcd_clk) begin
                if (last_fall >= 0 && c - last_fall != 1) clk_bad++;
                last_rise = c;
                clk_rises++;
            end
            if (clk_fall) begin
                if (last_rise >= 0 && c - last_rise != 2) clk_bad++;
                if (first_fall_c < 0) first_fall_c = c;
                last_fall = c;
            end
            if (cur_out != prev_out && !clk_fall) out_bad++;

            if (clk_fall) begin
                pix++;
                if (!lcd_de && rgb != 15'd0) rgb_bad++;
                if (prev_hs && !lcd_hsync) begin
                    if (last_hs_fall >= 0) begin
                        line_len = pix - last_hs_fall;
                        if (line_len != 1056) line_bad++;
                    end
                    last_hs_fall = pix;
                    lines++;
                    if (!lcd_vsync) vs_low_lines++;
                    if (vs_rise_seen && !bp_done) bp_lines++;
                end
                if (!lcd_hsync) hs_run++;
                if (!prev_hs && lcd_hsync) begin
                    hs_low_len = hs_run;
                    if (hs_run != 128) hs_bad++;
                    hs_run = 0;
                end
                if (!prev_de && lcd_de && vs_rise_seen) bp_done = 1'b1;
                if (lcd_de) begin
                    if (de_runs_total == 0) begin
                        case (de_x)
                            0:   cap0   = rgb;
                            99:  cap99  = rgb;
                            100: cap100 = rgb;
                            350: cap350 = rgb;
                            799: cap799 = rgb;
                            default: ;
                        endcase
                    end
                    de_x++;
                end
                if (prev_de && !lcd_de) begin
                    if (de_x != 800) de_bad++;
                    de_x = 0;
                    de_runs_total++;
                    de_runs_frame++;
                end
                if (prev_vs && !lcd_vsync) begin
                    if (last_vs_fall_line >= 0) begin
                        frame_lines    = lines - last_vs_fall_line;
                        frame_de_lines = de_runs_frame;
                    end
                    last_vs_fall_line = lines;
                    de_runs_frame = 0;
                    vs_low_lines  = 0;
                end
                if (!prev_vs && lcd_vsync) begin
                    vs_low_len   = vs_low_lines;
                    vs_rise_seen = 1'b1;
                    bp_lines     = 0;
                    bp_done      = 1'b0;
                end
            end
            prev_clk = lcd_clk;
            prev_out = cur_out;
        end

        chk("first_pixel_latency", 32'(first_fall_c), 32'd2);
        chk("lcd_clk_rises", 32'(clk_rises), 32'(RUN_CLKS / 3));
        chk("lcd_clk_shape_errs", 32'(clk_bad), 32'd0);
        chk("change_off_fall", 32'(out_bad), 32'd0);
        chk("line_len", 32'(line_len), 32'd1056);
        chk("line_len_errs", 32'(line_bad), 32'd0);
        chk("hsync_low", 32'(hs_low_len), 32'd128);
        chk("hsync_low_errs", 32'(hs_bad), 32'd0);
        chk("de_run_errs", 32'(de_bad), 32'd0);
        chk("de_runs_total", 32'(de_runs_total), 32'd8);
        chk("frame_lines", 32'(frame_lines), 32'(TB_VT));
        chk("frame_de_lines", 32'(frame_de_lines), 32'(TB_VA));
        chk("vsync_low_lines", 32'(vs_low_len), 32'd3);
        chk("back_porch_lines", 32'(bp_lines), 32'd2);
        chk("pix0_white", 32'(cap0), 32'h7FFF);
        chk("pix99_white", 32'(cap99), 32'h7FFF);
        chk("pix100_yellow", 32'(cap100), 32'h7FE0);
        chk("pix350_green", 32'(cap350), 32'h03E0);
        chk("pix799_black", 32'(cap799), 32'h0000);
        chk("rgb_when_no_de", 32'(rgb_bad), 32'd0);
        chk("x_on_outputs", 32'(x_bad), 32'd0);

        // Mid-line reset must take effect immediately and restart at (0,0)
        @(negedge clk);
        n_reset = 1'b0;
        #1;
        chk("midreset_outputs", 32'({lcd_clk, lcd_de, lcd_hsync, lcd_vsync, lcd_red, lcd_green, lcd_blue}),
            32'({1'b0, 1'b0, 1'b1, 1'b1, 15'd0}));
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
        chk("restart_clk_high", 32'(lcd_clk), 32'd1);
        @(negedge clk);
        chk("restart_de_not_yet", 32'(lcd_de), 32'd0);
        @(negedge clk);
        chk("restart_pixel0", 32'({lcd_clk, lcd_de, lcd_hsync, lcd_vsync, lcd_red, lcd_green, lcd_blue}),
            32'({1'b0, 1'b1, 1'b1, 1'b1, 15'h7FFF}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
